// File: rtl/fft_stream_core.sv
// Frame-based in-place radix-2 DIT FFT: bit-reversed load, one butterfly per cycle,
// natural-order output with backpressure, peak-bin (freq) report and done pulse.
//
// state  | meaning
// S_LOAD | accept N samples into bit-reversed buffer slots
// S_CALC | LOG2N stages of N/2 butterflies, one per cycle
// S_OUT  | stream bins 0..N-1, track peak |re|+|im|, pulse done after last
module fft_stream_core #(
   parameter int LOG2N = 4,
   parameter int DW    = 16,
   parameter int TW    = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fir_valid,
   input  logic [2*DW-1:0]        fir_d,
   output logic                   fir_ready,
   output logic [LOG2N-2:0]       tw_addr,
   input  logic signed [TW-1:0]   tw_re,
   input  logic signed [TW-1:0]   tw_im,
   output logic                   fft_valid,
   input  logic                   fft_ready,
   output logic [2*DW-1:0]        fft_d,
   output logic [LOG2N-1:0]       fft_idx,
   output logic                   done,
   output logic [LOG2N-1:0]       freq
);

   localparam int N  = 1 << LOG2N;
   localparam int SW = $clog2(LOG2N);
   localparam logic [LOG2N-1:0] ONE_N = 1;
   localparam logic [LOG2N-2:0] ONE_B = 1;
   localparam logic [SW-1:0]    ONE_S = 1;
   localparam logic [DW-1:0]    ZERO_D = '0;

   typedef enum logic [1:0] {S_LOAD, S_CALC, S_OUT} state_t;

   state_t r_state, w_state_nxt;

   logic signed [DW-1:0] r_buf_re [N];
   logic signed [DW-1:0] r_buf_im [N];

   logic [LOG2N-1:0] r_cnt;
   logic [SW-1:0]    r_stage;
   logic [LOG2N-2:0] r_bfly;
   logic [LOG2N-1:0] r_ocnt;
   logic [DW:0]      r_best;
   logic [LOG2N-1:0] r_best_idx;
   logic             r_fft_valid;
   logic [2*DW-1:0]  r_fft_d;
   logic [LOG2N-1:0] r_fft_idx;
   logic             r_done;
   logic [LOG2N-1:0] r_freq;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
      for (int i = 0; i < LOG2N; i++) bitrev[i] = v[LOG2N-1-i];
   endfunction

   logic w_last_bfly, w_last_stage, w_calc_end, w_out_xfer, w_out_last;
   assign w_last_bfly  = (r_bfly == '1);
   assign w_last_stage = (r_stage == SW'(LOG2N-1));
   assign w_calc_end   = (r_state == S_CALC) && w_last_bfly && w_last_stage;
   assign w_out_xfer   = (r_state == S_OUT) && r_fft_valid && fft_ready;
   assign w_out_last   = w_out_xfer && (r_ocnt == '1);

   // butterfly addressing: the low s bits of b pick the pair inside a group
   logic [LOG2N-1:0] w_b, w_half, w_low, w_top, w_bot, w_tw_full;
   logic             w_bypass;
   assign w_b       = {1'b0, r_bfly};
   assign w_half    = ONE_N << r_stage;
   assign w_low     = w_b & (w_half - ONE_N);
   assign w_top     = ((w_b >> r_stage) << ({1'b0, r_stage} + 1'b1)) | w_low;
   assign w_bot     = w_top | w_half;
   assign w_tw_full = w_low << (LOG2N - 1 - r_stage);
   assign w_bypass  = (w_low == '0);
   assign tw_addr   = (r_state == S_CALC) ? w_tw_full[LOG2N-2:0] : '0;

   logic signed [DW-1:0]   w_a_re, w_a_im, w_x_re, w_x_im;
   logic signed [DW+TW:0]  w_xr_e, w_xi_e, w_wr_e, w_wi_e, w_pr_re, w_pr_im;
   logic signed [DW+1:0]   w_t_re, w_t_im, w_a_re_e, w_a_im_e;
   logic signed [DW+1:0]   w_sum_re, w_sum_im, w_dif_re, w_dif_im;

   assign w_a_re  = r_buf_re[w_top];
   assign w_a_im  = r_buf_im[w_top];
   assign w_x_re  = r_buf_re[w_bot];
   assign w_x_im  = r_buf_im[w_bot];
   assign w_xr_e  = {{(TW+1){w_x_re[DW-1]}}, w_x_re};
   assign w_xi_e  = {{(TW+1){w_x_im[DW-1]}}, w_x_im};
   assign w_wr_e  = {{(DW+1){tw_re[TW-1]}}, tw_re};
   assign w_wi_e  = {{(DW+1){tw_im[TW-1]}}, tw_im};
   assign w_pr_re = w_xr_e * w_wr_e - w_xi_e * w_wi_e;
   assign w_pr_im = w_xr_e * w_wi_e + w_xi_e * w_wr_e;

   // W = 1 is not representable in Q1.(TW-1), so k = 0 passes bot through untouched
   assign w_t_re   = w_bypass ? {{2{w_x_re[DW-1]}}, w_x_re} : w_pr_re[DW+TW:TW-1];
   assign w_t_im   = w_bypass ? {{2{w_x_im[DW-1]}}, w_x_im} : w_pr_im[DW+TW:TW-1];
   assign w_a_re_e = {{2{w_a_re[DW-1]}}, w_a_re};
   assign w_a_im_e = {{2{w_a_im[DW-1]}}, w_a_im};
   assign w_sum_re = w_a_re_e + w_t_re;
   assign w_sum_im = w_a_im_e + w_t_im;
   assign w_dif_re = w_a_re_e - w_t_re;
   assign w_dif_im = w_a_im_e - w_t_im;

   logic [DW-1:0] w_out_re, w_out_im, w_abs_re, w_abs_im;
   logic [DW:0]   w_mag;
   logic          w_new_peak;
   logic [LOG2N-1:0] w_ocnt_nxt;
   assign w_out_re   = r_fft_d[2*DW-1:DW];
   assign w_out_im   = r_fft_d[DW-1:0];
   assign w_abs_re   = w_out_re[DW-1] ? (ZERO_D - w_out_re) : w_out_re;
   assign w_abs_im   = w_out_im[DW-1] ? (ZERO_D - w_out_im) : w_out_im;
   assign w_mag      = {1'b0, w_abs_re} + {1'b0, w_abs_im};
   assign w_new_peak = (w_mag > r_best);
   assign w_ocnt_nxt = r_ocnt + ONE_N;

   logic w_unused;
   assign w_unused = ^{w_pr_re[TW-2:0], w_pr_im[TW-2:0], w_sum_re[0], w_sum_im[0],
                       w_dif_re[0], w_dif_im[0], w_tw_full[LOG2N-1]};

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_LOAD;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_LOAD:  if (fir_valid && (r_cnt == '1)) w_state_nxt = S_CALC;
         S_CALC:  if (w_last_bfly && w_last_stage) w_state_nxt = S_OUT;
         S_OUT:   if (w_out_last) w_state_nxt = S_LOAD;
         default: w_state_nxt = S_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (r_state == S_LOAD && fir_valid) begin
         r_buf_re[bitrev(r_cnt)] <= fir_d[2*DW-1:DW];
         r_buf_im[bitrev(r_cnt)] <= fir_d[DW-1:0];
      end else if (r_state == S_CALC) begin
         r_buf_re[w_top] <= w_sum_re[DW:1];
         r_buf_im[w_top] <= w_sum_im[DW:1];
         r_buf_re[w_bot] <= w_dif_re[DW:1];
         r_buf_im[w_bot] <= w_dif_im[DW:1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_stage     <= '0;
         r_bfly      <= '0;
         r_ocnt      <= '0;
         r_best      <= '0;
         r_best_idx  <= '0;
         r_fft_valid <= 1'b0;
         r_fft_d     <= '0;
         r_fft_idx   <= '0;
         r_done      <= 1'b0;
         r_freq      <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_LOAD: if (fir_valid) r_cnt <= r_cnt + ONE_N;
            S_CALC: begin
               r_bfly <= r_bfly + ONE_B;
               if (w_last_bfly) r_stage <= w_last_stage ? '0 : r_stage + ONE_S;
               if (w_calc_end) begin
                  r_best     <= '0;
                  r_best_idx <= '0;
               end
            end
            S_OUT: begin
               if (!r_fft_valid) begin
                  r_fft_valid <= 1'b1;
                  r_fft_d     <= {r_buf_re[r_ocnt], r_buf_im[r_ocnt]};
                  r_fft_idx   <= r_ocnt;
               end else if (fft_ready) begin
                  if (w_new_peak) begin
                     r_best     <= w_mag;
                     r_best_idx <= r_fft_idx;
                  end
                  if (r_ocnt == '1) begin
                     r_fft_valid <= 1'b0;
                     r_done      <= 1'b1;
                     r_freq      <= w_new_peak ? r_fft_idx : r_best_idx;
                     r_ocnt      <= '0;
                  end else begin
                     r_ocnt    <= w_ocnt_nxt;
                     r_fft_d   <= {r_buf_re[w_ocnt_nxt], r_buf_im[w_ocnt_nxt]};
                     r_fft_idx <= w_ocnt_nxt;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign fir_ready = (r_state == S_LOAD);
   assign fft_valid = r_fft_valid;
   assign fft_d     = r_fft_d;
   assign fft_idx   = r_fft_idx;
   assign done      = r_done;
   assign freq      = r_freq;

endmodule

// File: doc/fft_stream_core.md
Name: fft_stream_core

Overview:
- Parametrised successor to the fixed 16-point pipelined FFT: a frame-based, memory-in-place radix-2 DIT FFT core with N = 2^LOG2N complex points.
- Sits between the FIR output stream and the spectrum consumer.
- Accepts one complex sample per handshake and computes one butterfly per cycle.
- Emits bins in natural order with backpressure, and reports the peak-magnitude bin (freq) with a done pulse per frame.

Parameters:
LOG2N, 4, log2 of FFT size; legal range 2..10 (N = 16 by default).
DW, 16, signed width of each real and imaginary component, both in and out.
TW, 16, twiddle width, signed Q1.(TW-1).

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous active-high reset.
fir_valid  in  1  input sample valid.
fir_d  in  2*DW  input sample {re[2*DW-1:DW], im[DW-1:0]}, signed.
fir_ready  out  1  core accepts a sample (state LOAD).
tw_addr  out  LOG2N-1  twiddle index k, combinational.
tw_re  in  TW  cos(2*pi*k/N), Q1.(TW-1), same-cycle combinational ROM return.
tw_im  in  TW  -sin(2*pi*k/N), Q1.(TW-1), same-cycle combinational ROM return.
fft_valid  out  1  output bin valid.
fft_ready  in  1  consumer accepts the bin.
fft_d  out  2*DW  bin value {re, im}.
fft_idx  out  LOG2N  bin index of fft_d.
done  out  1  one-cycle pulse on the transfer of bin N-1.
freq  out  LOG2N  peak bin index; updated with done, held until the next done.

Behaviour:
Reset (synchronous, active-high):
- State goes to LOAD; counters and peak tracker clear.
- fft_valid, done, freq, fft_d and fft_idx are 0.
- fir_ready is 1 in the first cycle after reset.
- Reset asserted in any state discards the current frame; the buffer contents are don't-care.

State LOAD:
- fir_ready = 1.
- Each cycle with fir_valid & fir_ready, the sample is written to buffer[bitrev(cnt)] and cnt increments.
- On the transfer with cnt = N-1, go to CALC.

State CALC:
- fir_ready = 0; fir_valid is ignored and no sample is lost or stored.
- Runs stages s = 0..LOG2N-1 with butterflies b = 0..N/2-1, one per cycle. CALC lasts exactly LOG2N*N/2 cycles (32 for N = 16).
- Per butterfly:
  - half = 2^s
  - top = ((b>>s)<<(s+1)) + (b & (half-1)); bot = top + half
  - tw_addr = (b & (half-1)) << (LOG2N-1-s)
- Arithmetic:
  - t = buffer[bot] * W, complex.
  - Products are full precision, arithmetic-shifted right by TW-1 (truncate).
  - When tw_addr = 0, t = buffer[bot] exactly (multiplier bypassed, because +1 is not representable in Q1.(TW-1)).
  - Write back: buffer[top] = (a+t)>>>1 and buffer[bot] = (a-t)>>>1, with the sum computed at DW+2 bits before the shift.
  - Total gain is 1/N, so there is no overflow for full-scale input.
- After the last butterfly, go to OUT.

State OUT:
- fft_valid = 1; fft_idx = ocnt (0..N-1); fft_d = buffer[ocnt], all registered.
- Transfer occurs when fft_valid & fft_ready. While fft_ready = 0, fft_d and fft_idx hold stable.
- Peak tracking:
  - mag = |re| + |im| at DW+1 bits, unsigned; the most-negative input saturates |x| to 2^(DW-1).
  - On each transfer, if mag > best (strict), update best and idx; ties keep the lower index.
- On the transfer of bin N-1:
  - done = 1 for exactly the following cycle.
  - freq = final best index.
  - fft_valid drops.
  - Next state is LOAD.

Latency:
- The first fft_valid is asserted LOG2N*N/2 + 1 cycles after the clock edge that accepts the final sample (33 for N = 16).
- fir_ready reasserts in the cycle done is high.

Test Plan:
1. Impulse: x0 = (1000, 0), x1..x15 = 0 -> all 16 bins (62, 0), since 1000>>>1 four times gives 62; freq = 0; done is a single pulse after idx 15.
2. DC: all samples (1600, 0) -> bin0 = (1600, 0), bins 1..15 = (0, 0) exactly; freq = 0.
3. Cosine at bin 4: x[n] = (1024*cos(pi*n/2), 0) -> bins 4 and 12 = (512, 0) within ±1 LSB; others within ±1; freq = 4 (tie goes to the lower index).
4. Backpressure: fft_ready held low for 3 cycles while fft_idx = 5 -> fft_d and fft_idx held stable; the output sequence is unbroken 0..15; done is delayed 3 cycles.
5. Handshake/ignore: fir_valid held high throughout CALC -> fir_ready = 0 for exactly 32 cycles; the first fft_valid appears 33 cycles after the 16th accept; the next frame's first sample is accepted only after done.
6. Reset mid-CALC (cycle 10 of CALC) -> the next cycle shows fir_ready = 1, fft_valid = 0, freq = 0; a fresh impulse frame then reproduces scenario 1.
